// File: rtl/cla_seq_pkg.sv
// Shared constants and types for the sequential carry-lookahead adder.
// Holds the slice width, controller state encoding and index-width helper.
package cla_seq_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Index register width for WIDTH/SLICE_W nibbles, never narrower than one bit.
   function automatic int idx_w(input int width);
      int n;
      n = width / SLICE_W;
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// Combinational 4-bit carry-lookahead slice: sum, carry into bit 3 and carry-out.
// Carries are flattened two-level lookahead terms, not a ripple chain.
module cla_slice4
   import cla_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               c3,
   output logic               cout
);

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic               c1;
   logic               c2;

   assign p = a | b;
   assign g = a & b;

   assign c1   = g[0] | (p[0] & cin);
   assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = a ^ b ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice walked LSB to MSB nibble.
// Optional subtraction (op_sub port) is built when CLA_SEQ_SUB_EN is defined.
module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int            N        = WIDTH / SLICE_W;
   localparam int            IW       = idx_w(WIDTH);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
   end

   state_e                          state;
   logic [IW-1:0]                   idx;
   logic [N-1:0][SLICE_W-1:0]       a_r;
   logic [N-1:0][SLICE_W-1:0]       b_r;
   logic [N-1:0][SLICE_W-1:0]       sum_r;
   logic                            carry_r;
   logic                            cout_r;
   logic                            ovf_r;

   logic [WIDTH-1:0]                b_in;
   logic                            c_in;
   logic [SLICE_W-1:0]              slice_sum;
   logic                            slice_c3;
   logic                            slice_cout;

   // Subtraction is a + ~b + 1, so it only changes what gets latched.
`ifdef CLA_SEQ_SUB_EN
   assign b_in = op_sub ? ~b : b;
   assign c_in = op_sub ? 1'b1 : cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   cla_slice4 u_slice (
      .a    (a_r[idx]),
      .b    (b_r[idx]),
      .cin  (carry_r),
      .sum  (slice_sum),
      .c3   (slice_c3),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               sum_r[idx] <= slice_sum;
               carry_r    <= slice_cout;
               // Last nibble: slice c3 is the carry into the result MSB.
               if (idx == IDX_LAST) begin
                  cout_r <= slice_cout;
                  ovf_r  <= slice_c3 ^ slice_cout;
                  state  <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               if (in_valid) begin
                  a_r     <= a;
                  b_r     <= b_in;
                  carry_r <= c_in;
                  idx     <= '0;
                  state   <= RUN;
               end
            end
         endcase
      end
   end

   assign busy      = (state == RUN) || (state == DONE);
   assign in_ready  = !busy;
   assign out_valid = (state == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;

endmodule
